load_store_unit: RTL and testbench

- Multi-cycle data-memory access stage. It sits directly downstream of the instruction decoder and consumes its per-access byte-enable masks (mem_r_enb / mem_w_enb), funct3, the ALU-computed address and the rs2 store data.
- It aligns the request onto a 32-bit word-addressed data-memory port using a req/gnt/rvalid handshake.
- For loads it sign- or zero-extends the returned data for register write-back.
- It stalls the core while an access is outstanding.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
// Handshake: the master holds dmem_req with addr/be/we/wdata stable until a cycle with
// dmem_gnt=1 (transfer accepted); a read then returns exactly one dmem_rvalid pulse with
// dmem_rdata, never in the grant cycle itself.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: aligns byte/half/word accesses onto a 32-bit word port,
// extends load data, stalls the core while outstanding and aborts on timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mem_r_enb,
  input  logic [3:0]  mem_w_enb,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic [1:0]  dbg_state,
  load_store_unit_if.master dmem
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, misal_q, berr_q, req_q, we_q, uns_q;
  logic [31:0]      rdata_q, addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [1:0]       off_q, size_q;

  logic [3:0]  mask;
  logic [1:0]  size;
  logic        bad_mask, misal, accept, timeout, load_fire;
  logic [31:0] wdata_rep, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        unused_funct3;

  assign unused_funct3 = ^funct3[1:0];

  assign mask   = mem_r_enb | mem_w_enb;
  assign accept = (state_q == S_IDLE) && start && (mask != 4'b0000);
  assign busy   = accept || (state_q == S_REQ) || (state_q == S_WAIT);

  // Any mask other than the three decoder encodings, or both masks set, is a bus error.
  always_comb begin
    size     = SZ_W;
    bad_mask = (|mem_r_enb) && (|mem_w_enb);
    case (mask)
      4'b0001: size = SZ_B;
      4'b0011: size = SZ_H;
      4'b1111: size = SZ_W;
      default: bad_mask = 1'b1;
    endcase
  end

  assign misal = ((size == SZ_H) && addr[0]) ||
                 ((size == SZ_W) && (addr[1:0] != 2'b00));

  always_comb begin
    case (size)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_b = dmem.dmem_rdata[7:0];
      2'd1:    lane_b = dmem.dmem_rdata[15:8];
      2'd2:    lane_b = dmem.dmem_rdata[23:16];
      default: lane_b = dmem.dmem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (size_q)
      SZ_B:    load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      SZ_H:    load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // The awaited event is checked before the timeout so it wins on the last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout   = 1'b0;
    load_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (bad_mask || misal) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_rvalid) begin
          state_d   = S_DONE;
          load_fire = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      misal_q <= 1'b0;
      berr_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_DONE);
      req_q   <= (state_d == S_REQ);
      if (accept) begin
        addr_q  <= {addr[31:2], 2'b00};
        we_q    <= |mem_w_enb;
        be_q    <= mask << addr[1:0];
        wdata_q <= wdata_rep;
        off_q   <= addr[1:0];
        size_q  <= size;
        uns_q   <= funct3[2];
        rdata_q <= '0;
        misal_q <= misal && !bad_mask;
        berr_q  <= bad_mask;
      end
      if (timeout) begin
        berr_q <= 1'b1;
      end
      if (load_fire) begin
        rdata_q <= load_ext;
      end
    end
  end

  assign done            = done_q;
  assign rdata           = rdata_q;
  assign misaligned      = misal_q;
  assign bus_err         = berr_q;
  assign dbg_state       = state_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized loads,
// with expected {misaligned, bus_err, rdata} results queued at issue time.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  mem_r_enb, mem_w_enb;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_v;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_r_enb(mem_r_enb), .mem_w_enb(mem_w_enb), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .dbg_state(dbg_state),
    .dmem(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_idle();
    start = 1'b0; mem_r_enb = 4'b0; mem_w_enb = 4'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
  endtask

  task automatic issue(input logic [3:0] r, input logic [3:0] w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; mem_r_enb = r; mem_w_enb = w; funct3 = f3; addr = a; wdata = d;
  endtask

  // Advance one cycle and scramble the core-side inputs to expose missing capture.
  task automatic next_cycle();
    @(negedge clk);
    start = 1'b0; mem_r_enb = 4'b0; mem_w_enb = 4'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input int sz,
                                             input logic [1:0] off, input bit uns);
    logic [31:0] sh;
    sh = word >> (8 * off);
    if (sz == 0) return uns ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
    if (sz == 1) return uns ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
    return word;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({done, misaligned, bus_err, rdata, bus.dmem_req, bus.dmem_we, bus.dmem_addr,
         bus.dmem_be, bus.dmem_wdata, busy, dbg_state} !== 108'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b req=%b addr=%h be=%h wdata=%h rdata=%h state=%0d exp all zero",
               done, bus.dmem_req, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, rdata, dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    exp_q.push_back({2'b00, 32'h0});
    issue(4'b0000, 4'b1111, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL store_busy_c0: got %b exp 1", busy); end
    next_cycle();
    n_tests++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata, busy} !==
        {1'b1, 1'b1, 4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL store_bus_c1: got req=%b we=%b be=%b addr=%h wdata=%h busy=%b exp 1 1 1111 10000004 deadbeef 1",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata, busy);
    end
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, busy, bus.dmem_req, misaligned, bus_err, rdata} !== {1'b1, 1'b0, 1'b0, exp_v}) begin
      n_fail++;
      $display("FAIL store_done_c2: got done=%b busy=%b req=%b flags/rdata=%h exp 1 0 0 %h",
               done, busy, bus.dmem_req, {misaligned, bus_err, rdata}, exp_v);
    end
    @(negedge clk);
    n_tests++;
    if ({done, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL store_done_pulse: got done=%b state=%0d exp 0 0", done, dbg_state);
    end
  endtask

  task automatic test_load_byte(input bit uns);
    logic [31:0] word;
    word = {8'h80, 24'($urandom)};
    exp_q.push_back({2'b00, uns ? 32'h0000_0080 : 32'hFFFF_FF80});
    issue(4'b0001, 4'b0000, {uns, 2'b00}, 32'h0000_0023, 32'h0);
    next_cycle();
    n_tests++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h20}) begin
      n_fail++;
      $display("FAIL lb_bus: got req=%b we=%b be=%b addr=%h exp 1 0 1000 00000020",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr);
    end
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    n_tests++;
    if ({bus.dmem_req, busy, done} !== 3'b010) begin
      n_fail++; $display("FAIL lb_wait: got req=%b busy=%b done=%b exp 0 1 0", bus.dmem_req, busy, done);
    end
    @(negedge clk);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = word;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, busy, misaligned, bus_err, rdata} !== {1'b1, 1'b0, exp_v}) begin
      n_fail++;
      $display("FAIL lb_result uns=%0d: got done=%b busy=%b flags/rdata=%h exp 1 0 %h",
               uns, done, busy, {misaligned, bus_err, rdata}, exp_v);
    end
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({done, rdata} !== {1'b0, exp_v[31:0]}) begin
      n_fail++; $display("FAIL lb_stale_rvalid: got done=%b rdata=%h exp 0 %h", done, rdata, exp_v[31:0]);
    end
  endtask

  task automatic test_half_store();
    exp_q.push_back({2'b00, 32'h0});
    issue(4'b0000, 4'b0011, 3'b001, 32'h0000_0006, 32'h1234_ABCD);
    next_cycle();
    n_tests++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata} !==
        {1'b1, 1'b1, 4'b1100, 32'h4, 32'hABCD_ABCD}) begin
      n_fail++;
      $display("FAIL sh_bus: got be=%b addr=%h wdata=%h exp 1100 00000004 abcdabcd",
               bus.dmem_be, bus.dmem_addr, bus.dmem_wdata);
    end
    next_cycle();
    n_tests++;
    if ({bus.dmem_req, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata} !== {1'b1, 4'b1100, 32'h4, 32'hABCD_ABCD}) begin
      n_fail++;
      $display("FAIL sh_hold: got req=%b be=%b addr=%h wdata=%h exp stable request",
               bus.dmem_req, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata);
    end
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, misaligned, bus_err, rdata} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL sh_done: got done=%b flags/rdata=%h exp 1 %h", done, {misaligned, bus_err, rdata}, exp_v);
    end
  endtask

  task automatic test_misaligned();
    exp_q.push_back({2'b10, 32'h0});
    issue(4'b1111, 4'b0000, 3'b010, 32'h0000_0002, 32'h0);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL lw_mis_busy: got %b exp 1", busy); end
    next_cycle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, bus.dmem_req, busy, misaligned, bus_err, rdata} !== {1'b1, 1'b0, 1'b0, exp_v}) begin
      n_fail++;
      $display("FAIL lw_mis_done: got done=%b req=%b busy=%b flags/rdata=%h exp 1 0 0 %h",
               done, bus.dmem_req, busy, {misaligned, bus_err, rdata}, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.dmem_req, done} !== 2'b00) begin
        n_fail++; $display("FAIL lw_mis_no_req: got req=%b done=%b exp 0 0", bus.dmem_req, done);
      end
    end
    issue(4'b0000, 4'b0011, 3'b001, 32'h0000_0001, 32'h5555_5555);
    next_cycle();
    n_tests++;
    if ({done, misaligned, bus_err, bus.dmem_req} !== 4'b1100) begin
      n_fail++;
      $display("FAIL sh_mis: got done=%b mis=%b err=%b req=%b exp 1 1 0 0", done, misaligned, bus_err, bus.dmem_req);
    end
  endtask

  task automatic test_illegal_and_ignored();
    issue(4'b0001, 4'b0001, 3'b000, 32'h0000_0010, 32'h0);
    next_cycle();
    n_tests++;
    if ({done, misaligned, bus_err, bus.dmem_req} !== 4'b1010) begin
      n_fail++;
      $display("FAIL illegal_mask: got done=%b mis=%b err=%b req=%b exp 1 0 1 0", done, misaligned, bus_err, bus.dmem_req);
    end
    issue(4'b0000, 4'b0000, 3'b000, 32'h0000_0010, 32'h0);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_mask_busy: got %b exp 0", busy); end
    next_cycle();
    n_tests++;
    if ({done, dbg_state, bus_err} !== 4'b0001) begin
      n_fail++; $display("FAIL zero_mask_ignored: got done=%b state=%0d err=%b exp 0 0 1", done, dbg_state, bus_err);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    exp_q.push_back({2'b01, 32'h0});
    issue(4'b0000, 4'b1111, 3'b010, 32'h0000_0040, 32'h0BAD_F00D);
    next_cycle();
    req_cycles = 0;
    for (int i = 0; i < 10 && done !== 1'b1; i++) begin
      if (bus.dmem_req === 1'b1) req_cycles++;
      @(negedge clk);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, bus.dmem_req, misaligned, bus_err, rdata} !== {1'b1, 1'b0, exp_v}) begin
      n_fail++;
      $display("FAIL timeout_done: got done=%b req=%b flags/rdata=%h exp 1 0 %h",
               done, bus.dmem_req, {misaligned, bus_err, rdata}, exp_v);
    end
    n_tests++;
    if (req_cycles !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d exp 4", req_cycles); end
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    n_tests++;
    if ({done, bus.dmem_req, busy, bus_err} !== 4'b0001) begin
      n_fail++; $display("FAIL timeout_late_gnt: got done=%b req=%b busy=%b err=%b exp 0 0 0 1", done, bus.dmem_req, busy, bus_err);
    end
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    n_tests++;
    if ({done, rdata} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL timeout_late_rvalid: got done=%b rdata=%h exp 0 00000000", done, rdata);
    end
  endtask

  task automatic test_timeout_boundary();
    exp_q.push_back({2'b00, 32'h0});
    issue(4'b0000, 4'b0001, 3'b000, 32'h0000_0081, 32'h0000_00AA);
    next_cycle();
    repeat (3) @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, misaligned, bus_err, rdata} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL gnt_last_cycle: got done=%b flags/rdata=%h exp 1 %h", done, {misaligned, bus_err, rdata}, exp_v);
    end
    exp_q.push_back({2'b00, 32'hFFFF_9ABC});
    issue(4'b0011, 4'b0000, 3'b001, 32'h0000_0012, 32'h0);
    next_cycle();
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h9ABC_1234;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, misaligned, bus_err, rdata} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL rvalid_last_cycle: got done=%b flags/rdata=%h exp 1 %h", done, {misaligned, bus_err, rdata}, exp_v);
    end
  endtask

  task automatic test_mid_reset();
    issue(4'b1111, 4'b0000, 3'b010, 32'h0000_0080, 32'h0);
    next_cycle();
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({done, misaligned, bus_err, rdata, bus.dmem_req, bus.dmem_we, bus.dmem_addr,
         bus.dmem_be, bus.dmem_wdata, busy, dbg_state} !== 108'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got done=%b req=%b addr=%h be=%h busy=%b state=%0d exp all zero",
               done, bus.dmem_req, bus.dmem_addr, bus.dmem_be, busy, dbg_state);
    end
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0000_0055;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    n_tests++;
    if ({done, rdata} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL mid_reset_rvalid: got done=%b rdata=%h exp 0 00000000", done, rdata);
    end
  endtask

  task automatic test_random_loads();
    int sz, g, r;
    bit uns;
    logic [1:0]  off;
    logic [3:0]  m;
    logic [31:0] word, base;
    for (int k = 0; k < 10; k++) begin
      sz   = $urandom_range(0, 2);
      uns  = 1'($urandom_range(0, 1));
      g    = $urandom_range(0, 1);
      r    = $urandom_range(0, 1);
      word = $urandom;
      base = {$urandom, 2'b00} & 32'h0000_FFFC;
      off  = (sz == 0) ? 2'($urandom_range(0, 3)) : (sz == 1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      m    = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
      exp_q.push_back({2'b00, model_load(word, sz, off, uns)});
      issue(m, 4'b0000, {uns, 2'(sz)}, base | {30'h0, off}, 32'h0);
      next_cycle();
      repeat (g) @(negedge clk);
      bus.dmem_gnt = 1'b1;
      @(negedge clk);
      bus.dmem_gnt = 1'b0;
      repeat (r) @(negedge clk);
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = word;
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      exp_v = exp_q.pop_front();
      n_tests++;
      if ({done, misaligned, bus_err, rdata} !== {1'b1, exp_v}) begin
        n_fail++;
        $display("FAIL rand_load k=%0d sz=%0d off=%0d uns=%0d word=%h: got done=%b flags/rdata=%h exp 1 %h",
                 k, sz, off, uns, word, done, {misaligned, bus_err, rdata}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] word;
    word = $urandom | 32'h1;
    issue(4'b1111, 4'b0000, 3'b010, 32'h0000_0100, 32'h0);
    next_cycle();
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = word;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    start = 1'b1; mem_r_enb = 4'b0; mem_w_enb = 4'b1111; funct3 = 3'b010;
    addr = 32'h0000_0200; wdata = 32'hCAFE_F00D;
    #1;
    n_tests++;
    if ({done, busy, rdata} !== {1'b1, 1'b0, word}) begin
      n_fail++; $display("FAIL b2b_in_done: got done=%b busy=%b rdata=%h exp 1 0 %h", done, busy, rdata, word);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({done, dbg_state, busy, rdata} !== {1'b0, 2'd0, 1'b1, word}) begin
      n_fail++;
      $display("FAIL b2b_idle_accept: got done=%b state=%0d busy=%b rdata=%h exp 0 0 1 %h", done, dbg_state, busy, rdata, word);
    end
    exp_q.push_back({2'b00, 32'h0});
    next_cycle();
    n_tests++;
    if ({bus.dmem_req, bus.dmem_addr, bus.dmem_wdata, rdata} !== {1'b1, 32'h200, 32'hCAFE_F00D, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_second_req: got req=%b addr=%h wdata=%h rdata=%h exp 1 00000200 cafef00d 00000000",
               bus.dmem_req, bus.dmem_addr, bus.dmem_wdata, rdata);
    end
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({done, misaligned, bus_err, rdata} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL b2b_second_done: got done=%b flags/rdata=%h exp 1 %h", done, {misaligned, bus_err, rdata}, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte(1'b0);
    test_load_byte(1'b1);
    test_half_store();
    test_misaligned();
    test_illegal_and_ignored();
    test_timeout();
    test_timeout_boundary();
    test_mid_reset();
    test_random_loads();
    test_back_to_back();
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
